// File: rtl/fpuadd64_sched.sv
// Round-robin issue scheduler and tagged result router for the shared fpuadd64 unit.
// Grant-to-result latency is LAT+2 at one op per cycle. Results have no backpressure; per-requester credits throttle issue.
module fpuadd64_sched #(
  parameter int NREQ    = 4,
  parameter int LAT     = 2,
  parameter int CREDITS = 3,
  parameter int IDW     = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_vld,
  input  logic [2*NREQ-1:0]    req_op,
  input  logic [NREQ-1:0]      req_rnd,
  input  logic [64*NREQ-1:0]   req_a,
  input  logic [64*NREQ-1:0]   req_b,
  output logic [NREQ-1:0]      req_gnt,
  input  logic [NREQ-1:0]      cr_ret,
  output logic [63:0]          fa_A,
  output logic [63:0]          fa_B,
  output logic                 fa_rnd,
  output logic                 fa_pookm,
  output logic                 fa_pookg,
  input  logic [63:0]          fa_res,
  output logic                 res_vld,
  output logic [IDW-1:0]       res_id,
  output logic [63:0]          res_data,
  input  logic                 flush,
  output logic                 idle
);

  typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, HALT = 2'd2} state_e;
  localparam logic [2:0] CRED_MAX = 3'(CREDITS);

  state_e          state_q, state_d;
  logic [IDW-1:0]  rr_q, rr_d;
  logic [2:0]      cred_q [NREQ];
  logic [2:0]      cred_d [NREQ];
  logic [NREQ-1:0] elig;
  logic            gnt_any;
  logic [IDW-1:0]  gnt_id;
  logic [63:0]     sel_a, sel_b;
  logic [1:0]      sel_op;
  logic            sel_rnd;
  logic [63:0]     fa_a_q, fa_b_q;
  logic            fa_rnd_q, fa_pookm_q;
  logic [LAT:0]    sv_q, sest_q;
  logic [IDW-1:0]  sid_q [LAT+1];
  logic            res_vld_q;
  logic [IDW-1:0]  res_id_q;
  logic [63:0]     res_data_q;
  logic            busy;

  // Grants are suppressed while reset is held so no credit is spent on a discarded op.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NREQ; i++)
      elig[i] = req_vld[i] && (cred_q[i] != 3'd0) && (state_q == RUN) && !rst;
  end

  always_comb begin
    logic [IDW-1:0] cand;
    gnt_any = 1'b0;
    gnt_id  = '0;
    req_gnt = '0;
    cand    = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IDW'((int'(rr_q) + k) % NREQ);
      if (!gnt_any && elig[cand]) begin
        gnt_any = 1'b1;
        gnt_id  = cand;
      end
    end
    if (gnt_any) req_gnt[gnt_id] = 1'b1;
  end

  assign rr_d = gnt_any ? IDW'((int'(gnt_id) + 1) % NREQ) : rr_q;

  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    sel_op  = '0;
    sel_rnd = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_any && gnt_id == IDW'(i)) begin
        sel_a   = req_a[64*i +: 64];
        sel_b   = req_b[64*i +: 64];
        sel_op  = req_op[2*i +: 2];
        sel_rnd = req_rnd[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      cred_d[i] = cred_q[i];
      if (req_gnt[i] && !cr_ret[i])
        cred_d[i] = cred_q[i] - 3'd1;
      else if (!req_gnt[i] && cr_ret[i] && cred_q[i] != CRED_MAX)
        cred_d[i] = cred_q[i] + 3'd1;
    end
  end

  assign busy = (|sv_q) || res_vld_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (flush) state_d = DRAIN;
      DRAIN:   if (!busy) state_d = HALT;
      HALT:    if (!flush) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      rr_q       <= '0;
      for (int i = 0; i < NREQ; i++) cred_q[i] <= CRED_MAX;
      fa_a_q     <= '0;
      fa_b_q     <= '0;
      fa_rnd_q   <= 1'b0;
      fa_pookm_q <= 1'b0;
      sv_q       <= '0;
      sest_q     <= '0;
      for (int s = 0; s <= LAT; s++) sid_q[s] <= '0;
      res_vld_q  <= 1'b0;
      res_id_q   <= '0;
      res_data_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      for (int i = 0; i < NREQ; i++) cred_q[i] <= cred_d[i];
      fa_a_q     <= sel_a;
      fa_b_q     <= sel_b;
      // Estimates force the rounding pin: 0 for reciprocal, 1 for rsqrt.
      fa_rnd_q   <= gnt_any && (sel_op[1] ? sel_op[0] : sel_rnd);
      fa_pookm_q <= gnt_any && (sel_op == 2'b01);
      sv_q       <= {sv_q[LAT-1:0], gnt_any};
      sest_q     <= {sest_q[LAT-1:0], sel_op[1]};
      sid_q[0]   <= gnt_id;
      for (int s = 1; s <= LAT; s++) sid_q[s] <= sid_q[s-1];
      res_vld_q  <= sv_q[LAT];
      res_id_q   <= sid_q[LAT];
      if (sv_q[LAT]) res_data_q <= fa_res;
    end
  end

  assign fa_A     = fa_a_q;
  assign fa_B     = fa_b_q;
  assign fa_rnd   = fa_rnd_q;
  assign fa_pookm = fa_pookm_q;
  assign fa_pookg = sv_q[LAT] & sest_q[LAT];
  assign res_vld  = res_vld_q;
  assign res_id   = res_id_q;
  assign res_data = res_data_q;
  assign idle     = (state_q == HALT);

endmodule
